// File: rtl/seq_code_lock.sv
// Sequential code lock: SEQ_LEN valid-qualified entries in order open the lock; repeated
// failures cause a timed lockout. Define SEQLOCK_PROG_EN for a sequence writable while OPEN.
module seq_code_lock #(
    parameter int                          CODE_W      = 8,
    parameter int                          SEQ_LEN     = 3,
    parameter logic [SEQ_LEN*CODE_W-1:0]   SEQ_INIT    = {8'hcc, 8'hbb, 8'haa},
    parameter int                          MAX_FAIL    = 3,
    parameter int                          LOCKOUT_CYC = 16,
    parameter int                          OPEN_CYC    = 0,
    localparam int                         IDX_W       = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
    localparam int                         PW          = $clog2(SEQ_LEN + 1),
    localparam int                         FW          = $clog2(MAX_FAIL + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code,
    input  logic              relock,
    input  logic              prog_valid,
    input  logic [IDX_W-1:0]  prog_idx,
    input  logic [CODE_W-1:0] prog_data,
    output logic [1:0]        state,
    output logic              unlocked,
    output logic [PW-1:0]     progress,
    output logic [FW-1:0]     fail_cnt,
    output logic              lockout
);

    localparam int LW = $clog2(LOCKOUT_CYC + 1);
    localparam int OW = (OPEN_CYC > 0) ? $clog2(OPEN_CYC + 1) : 1;

    typedef enum logic [1:0] {
        ST_LOCKED  = 2'b00,
        ST_OPEN    = 2'b01,
        ST_LOCKOUT = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_e;

    state_e                     state_q, state_d;
    logic [PW-1:0]              progress_q, progress_d;
    logic [FW-1:0]              fail_q, fail_d;
    logic [LW-1:0]              lock_tmr_q, lock_tmr_d;
    logic [OW-1:0]              open_tmr_q, open_tmr_d;
    logic                       unlocked_q, unlocked_d;
    logic                       lockout_q, lockout_d;
    logic [SEQ_LEN*CODE_W-1:0]  seq_s;
    logic [CODE_W-1:0]          expected_s;

    function automatic logic [CODE_W-1:0] entry_at(input logic [SEQ_LEN*CODE_W-1:0] vec,
                                                   input logic [PW-1:0]              idx);
        logic [CODE_W-1:0] r;
        r = {CODE_W{1'b0}};
        for (int i = 0; i < SEQ_LEN; i++) begin
            r = (int'(idx) == i) ? vec[i*CODE_W +: CODE_W] : r;
        end
        return r;
    endfunction

`ifdef SEQLOCK_PROG_EN
    logic [SEQ_LEN*CODE_W-1:0] seq_q, seq_d;

    // Sequence store write port, open only while the lock is OPEN.
    always_comb begin
        seq_d = seq_q;
        if (prog_valid && (state_q == ST_OPEN) && (int'(prog_idx) < SEQ_LEN)) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                seq_d[i*CODE_W +: CODE_W] = (int'(prog_idx) == i) ? prog_data
                                                                  : seq_q[i*CODE_W +: CODE_W];
            end
        end else begin
            seq_d = seq_q;
        end
    end

    // Sequence store registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_q <= SEQ_INIT;
        end else begin
            seq_q <= seq_d;
        end
    end

    assign seq_s = seq_q;
`else
    logic prog_unused_s;
    assign prog_unused_s = &{1'b0, prog_valid, prog_idx, prog_data};
    assign seq_s         = SEQ_INIT;
`endif

    assign expected_s = entry_at(seq_s, progress_q);

    // Next-state and counter logic for the lock FSM.
    always_comb begin
        state_d    = state_q;
        progress_d = progress_q;
        fail_d     = fail_q;
        lock_tmr_d = lock_tmr_q;
        open_tmr_d = open_tmr_q;
        case (state_q)
            ST_LOCKED: begin
                if (code_valid) begin
                    if (code == expected_s) begin
                        if (progress_q == PW'(SEQ_LEN - 1)) begin
                            state_d    = ST_OPEN;
                            progress_d = {PW{1'b0}};
                            fail_d     = {FW{1'b0}};
                            open_tmr_d = OW'(OPEN_CYC);
                        end else begin
                            progress_d = progress_q + PW'(1);
                        end
                    end else begin
                        // A wrong entry restarts the sequence; it is not retried as entry 0.
                        progress_d = {PW{1'b0}};
                        if (fail_q >= FW'(MAX_FAIL - 1)) begin
                            fail_d     = FW'(MAX_FAIL);
                            state_d    = ST_LOCKOUT;
                            lock_tmr_d = LW'(LOCKOUT_CYC);
                        end else begin
                            fail_d = fail_q + FW'(1);
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_OPEN: begin
                if (relock) begin
                    state_d    = ST_LOCKED;
                    open_tmr_d = {OW{1'b0}};
                end else if (OPEN_CYC == 0) begin
                    open_tmr_d = open_tmr_q;
                end else if (open_tmr_q <= OW'(1)) begin
                    state_d    = ST_LOCKED;
                    open_tmr_d = {OW{1'b0}};
                end else begin
                    open_tmr_d = open_tmr_q - OW'(1);
                end
            end
            ST_LOCKOUT: begin
                if (lock_tmr_q <= LW'(1)) begin
                    state_d    = ST_LOCKED;
                    lock_tmr_d = {LW{1'b0}};
                    fail_d     = {FW{1'b0}};
                    progress_d = {PW{1'b0}};
                end else begin
                    lock_tmr_d = lock_tmr_q - LW'(1);
                end
            end
            default: begin
                state_d    = ST_LOCKED;
                progress_d = {PW{1'b0}};
                fail_d     = {FW{1'b0}};
                lock_tmr_d = {LW{1'b0}};
                open_tmr_d = {OW{1'b0}};
            end
        endcase
        unlocked_d = (state_d == ST_OPEN);
        lockout_d  = (state_d == ST_LOCKOUT);
    end

    // FSM state, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_LOCKED;
            progress_q <= {PW{1'b0}};
            fail_q     <= {FW{1'b0}};
            lock_tmr_q <= {LW{1'b0}};
            open_tmr_q <= {OW{1'b0}};
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            progress_q <= progress_d;
            fail_q     <= fail_d;
            lock_tmr_q <= lock_tmr_d;
            open_tmr_q <= open_tmr_d;
            unlocked_q <= unlocked_d;
            lockout_q  <= lockout_d;
        end
    end

    assign state    = state_q;
    assign unlocked = unlocked_q;
    assign progress = progress_q;
    assign fail_cnt = fail_q;
    assign lockout  = lockout_q;

endmodule

// File: tb/tb_seq_code_lock.sv
// Bench for seq_code_lock: two instances (OPEN_CYC=0 and OPEN_CYC=5) against a reference model.
module tb_seq_code_lock;

`ifdef SEQLOCK_PROG_EN
    localparam bit PROG_EN = 1'b1;
`else
    localparam bit PROG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, code_valid, relock, prog_valid;
    logic [7:0] code, prog_data;
    logic [1:0] prog_idx;
    logic [1:0] st0, st1, pg0, pg1, fc0, fc1;
    logic       unl0, unl1, lo0, lo1;

    always #5 clk = ~clk;

    seq_code_lock dut0 (
        .clk(clk), .reset(reset), .code_valid(code_valid), .code(code), .relock(relock),
        .prog_valid(prog_valid), .prog_idx(prog_idx), .prog_data(prog_data),
        .state(st0), .unlocked(unl0), .progress(pg0), .fail_cnt(fc0), .lockout(lo0));

    seq_code_lock #(.OPEN_CYC(5)) dut1 (
        .clk(clk), .reset(reset), .code_valid(code_valid), .code(code), .relock(relock),
        .prog_valid(prog_valid), .prog_idx(prog_idx), .prog_data(prog_data),
        .state(st1), .unlocked(unl1), .progress(pg1), .fail_cnt(fc1), .lockout(lo1));

    int n_tests = 0;
    int n_fail  = 0;

    // Model: 0 LOCKED, 1 OPEN, 2 LOCKOUT; m_tmr is cycles of the current timed state left.
    int m_state[2], m_prog[2], m_fail[2], m_tmr[2];
    int m_seq[2][3];

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int  oc;
            bit  wr;
            oc = (k == 0) ? 0 : 5;
            if (reset) begin
                m_state[k] = 0; m_prog[k] = 0; m_fail[k] = 0; m_tmr[k] = 0;
                m_seq[k][0] = 'haa; m_seq[k][1] = 'hbb; m_seq[k][2] = 'hcc;
            end else begin
                wr = PROG_EN && prog_valid && (m_state[k] == 1) && (prog_idx < 3);
                case (m_state[k])
                    0: if (code_valid) begin
                        if (int'(code) == m_seq[k][m_prog[k]]) begin
                            m_prog[k]++;
                            if (m_prog[k] == 3) begin
                                m_state[k] = 1; m_prog[k] = 0; m_fail[k] = 0; m_tmr[k] = oc;
                            end
                        end else begin
                            m_prog[k] = 0;
                            m_fail[k]++;
                            if (m_fail[k] == 3) begin
                                m_state[k] = 2; m_tmr[k] = 16;
                            end
                        end
                    end
                    1: if (relock) m_state[k] = 0;
                       else if (oc > 0) begin
                           m_tmr[k]--;
                           if (m_tmr[k] == 0) m_state[k] = 0;
                       end
                    2: begin
                        m_tmr[k]--;
                        if (m_tmr[k] == 0) begin
                            m_state[k] = 0; m_fail[k] = 0; m_prog[k] = 0;
                        end
                    end
                    default: m_state[k] = 0;
                endcase
                if (wr) m_seq[k][int'(prog_idx)] = int'(prog_data);
            end
        end
    endtask

    task automatic check(input int k, input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d got %0d want %0d at %0t", name, k, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check(0, "state",    int'(st0),  m_state[0]);
        check(0, "unlocked", int'(unl0), int'(m_state[0] == 1));
        check(0, "progress", int'(pg0),  m_prog[0]);
        check(0, "fail_cnt", int'(fc0),  m_fail[0]);
        check(0, "lockout",  int'(lo0),  int'(m_state[0] == 2));
        check(1, "state",    int'(st1),  m_state[1]);
        check(1, "unlocked", int'(unl1), int'(m_state[1] == 1));
        check(1, "progress", int'(pg1),  m_prog[1]);
        check(1, "fail_cnt", int'(fc1),  m_fail[1]);
        check(1, "lockout",  int'(lo1),  int'(m_state[1] == 2));
    endtask

    task automatic cyc(input logic r, input logic cv, input logic [7:0] c, input logic rl,
                       input logic pv, input logic [1:0] pi, input logic [7:0] pd);
        reset = r; code_valid = cv; code = c; relock = rl;
        prog_valid = pv; prog_idx = pi; prog_data = pd;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic enter(input logic [7:0] c);
        cyc(1'b0, 1'b1, c, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    typedef struct {
        logic       rst;
        logic       cv;
        logic [7:0] code;
        logic       rl;
        int         st;
        int         pg;
        int         fc;
    } vec_t;

    vec_t tbl[17];
    int   cnt;
    logic [7:0] pick;

    initial begin
        reset = 1'b1; code_valid = 1'b0; code = 8'h00; relock = 1'b0;
        prog_valid = 1'b0; prog_idx = 2'd0; prog_data = 8'h00;
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_prog[k] = 0; m_fail[k] = 0; m_tmr[k] = 0;
            m_seq[k][0] = 'haa; m_seq[k][1] = 'hbb; m_seq[k][2] = 'hcc;
        end

        // Expected values for instance 0 (OPEN_CYC=0).
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 0, 0};
        tbl[1]  = '{1'b0, 1'b1, 8'haa, 1'b0, 0, 1, 0};
        tbl[2]  = '{1'b0, 1'b1, 8'hbb, 1'b0, 0, 2, 0};
        tbl[3]  = '{1'b0, 1'b1, 8'hcc, 1'b0, 1, 0, 0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 0, 0};
        tbl[5]  = '{1'b0, 1'b1, 8'haa, 1'b0, 0, 1, 0};
        tbl[6]  = '{1'b0, 1'b1, 8'hbb, 1'b0, 0, 2, 0};
        tbl[7]  = '{1'b0, 1'b1, 8'h12, 1'b0, 0, 0, 1};
        tbl[8]  = '{1'b0, 1'b0, 8'haa, 1'b0, 0, 0, 1};
        tbl[9]  = '{1'b0, 1'b1, 8'haa, 1'b0, 0, 1, 1};
        tbl[10] = '{1'b0, 1'b1, 8'hbb, 1'b0, 0, 2, 1};
        tbl[11] = '{1'b0, 1'b1, 8'hcc, 1'b0, 1, 0, 0};
        tbl[12] = '{1'b0, 1'b1, 8'haa, 1'b0, 1, 0, 0};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 0, 0};
        tbl[14] = '{1'b0, 1'b1, 8'hbb, 1'b0, 0, 0, 1};
        tbl[15] = '{1'b0, 1'b1, 8'haa, 1'b0, 0, 1, 1};
        tbl[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 0, 0};

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].rst, tbl[i].cv, tbl[i].code, tbl[i].rl, 1'b0, 2'd0, 8'h00);
            check(0, "tbl_state",    int'(st0),  tbl[i].st);
            check(0, "tbl_unlocked", int'(unl0), int'(tbl[i].st == 1));
            check(0, "tbl_progress", int'(pg0),  tbl[i].pg);
            check(0, "tbl_fail_cnt", int'(fc0),  tbl[i].fc);
        end

        // Lockout: three wrong entries, correct code ignored during lockout.
        enter(8'h00); enter(8'h00); enter(8'h00);
        check(0, "lockout_entry", int'(st0), 2);
        cnt = int'(lo0);
        for (int i = 0; i < 40 && lo0; i++) begin
            if (i == 0) enter(8'haa);
            else if (i == 1) enter(8'hbb);
            else if (i == 2) enter(8'hcc);
            else idle();
            if (lo0) cnt++;
        end
        check(0, "lockout_len", cnt, 16);
        check(0, "lockout_exit_state", int'(st0), 0);
        check(0, "lockout_exit_fail",  int'(fc0), 0);

        // Auto-relock after 5 cycles on instance 1, manual relock on instance 0.
        enter(8'haa); enter(8'hbb); enter(8'hcc);
        cnt = int'(unl1);
        for (int i = 0; i < 20; i++) begin
            idle();
            if (unl1) cnt++;
        end
        check(1, "open_len", cnt, 5);
        check(0, "open_hold", int'(unl0), 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00);
        check(0, "relock_state", int'(st0), 0);

        // Relock coinciding with the final open cycle of instance 1.
        enter(8'haa); enter(8'hbb); enter(8'hcc);
        idle(); idle(); idle(); idle();
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00);
        check(1, "relock_expiry", int'(st1), 0);

        // Reset mid-sequence and during lockout.
        enter(8'haa); enter(8'hbb);
        check(0, "mid_progress", int'(pg0), 2);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
        check(0, "rst_mid_progress", int'(pg0), 0);
        enter(8'h00); enter(8'h00); enter(8'h00); idle(); idle();
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
        check(0, "rst_lockout", int'(lo0), 0);
        check(0, "rst_lockout_state", int'(st0), 0);
        check(0, "rst_lockout_fail", int'(fc0), 0);

        // Sequence programming while OPEN.
        enter(8'haa); enter(8'hbb); enter(8'hcc);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 8'h11);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 8'h22);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 8'h33);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 8'h44);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00);
        enter(8'haa);
        check(0, "prog_old_aa", int'(pg0), PROG_EN ? 0 : 1);
        enter(8'h11); enter(8'h22); enter(8'h33);
        check(0, "prog_new_seq", int'(st0), PROG_EN ? 1 : 2);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       pick = 8'haa;
                1:       pick = 8'hbb;
                2:       pick = 8'hcc;
                default: pick = 8'($urandom);
            endcase
            cyc(1'b0 | ($urandom_range(0, 199) == 0),
                1'($urandom),
                ($urandom_range(0, 3) != 0) ? 8'(m_seq[0][m_prog[0]]) : 8'($urandom),
                1'b0 | ($urandom_range(0, 15) == 0),
                1'b0 | ($urandom_range(0, 7) == 0),
                2'($urandom),
                pick);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
